// File: rtl/audio_pkg.sv
// Shared types and constants for the audio sample scheduler and its
// neighbours: sample format, accumulator format and the scheduler FSM states.
package audio_pkg;

  localparam int SAMPLE_W = 14;
  localparam int ACC_W    = 17;
  localparam int GAIN_W   = 7;
  localparam int GAIN_MAX = 64;

  typedef logic signed [SAMPLE_W-1:0] sample_t;
  typedef logic signed [ACC_W-1:0]    acc_t;

  localparam sample_t SAMPLE_MAX = sample_t'(14'h1FFF);
  localparam sample_t SAMPLE_MIN = sample_t'(14'h2000);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_GATHER,
    ST_SCALE,
    ST_OUT
  } state_e;

endpackage

// File: rtl/audio_sample_scheduler_if.sv
// Voice handshake and DAC-side sample bus of the audio sample scheduler.
// slave: the scheduler; master: the voices/DAC environment driving it.
interface audio_sample_scheduler_if #(
  parameter int NUM_VOICES = 3
);
  import audio_pkg::*;

  logic                           enable_i;
  logic [NUM_VOICES-1:0]          voice_valid_i;
  logic [SAMPLE_W*NUM_VOICES-1:0] voice_data_i;
  logic [NUM_VOICES-1:0]          voice_ready_o;
  logic                           audio_valid_o;
  sample_t                        audio_o;
  logic                           clip_o;
  logic                           underrun_o;

  modport slave (
    input  enable_i,
    input  voice_valid_i,
    input  voice_data_i,
    output voice_ready_o,
    output audio_valid_o,
    output audio_o,
    output clip_o,
    output underrun_o
  );

  modport master (
    output enable_i,
    output voice_valid_i,
    output voice_data_i,
    input  voice_ready_o,
    input  audio_valid_o,
    input  audio_o,
    input  clip_o,
    input  underrun_o
  );

endinterface

// File: rtl/sample_tick_gen.sv
// Free-running modulo-SAMPLE_DIV counter producing a one-cycle tick on the
// last count. Reusable by any block that needs a fixed-rate strobe.
module sample_tick_gen #(
  parameter int SAMPLE_DIV = 1042
) (
  input  logic clk_i,
  input  logic rst_i,
  output logic tick_o
);

  localparam int CNT_W = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SAMPLE_DIV - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Tick on the last count, then wrap to zero.
  always_comb begin
    tick_o = (cnt_q == CNT_LAST);
    cnt_d  = tick_o ? '0 : cnt_q + CNT_W'(1);
  end

  // Counter register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/audio_sample_scheduler.sv
// Audio sample scheduler: on each sample tick, visits every voice once in
// ascending order, sums the accepted (or last held) samples, saturates to
// 14 bits, applies the mute stage and strobes the result to the DAC.
// Optional feature macro: SOFT_MUTE_EN (click-free gain ramp instead of a
// hard mute).
module audio_sample_scheduler
  import audio_pkg::*;
#(
  parameter int NUM_VOICES = 3,
  parameter int SAMPLE_DIV = 1042
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  audio_sample_scheduler_if.slave  bus
);

  localparam int SLOT_W = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
  localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(NUM_VOICES - 1);

  function automatic sample_t saturate(input acc_t a);
    if (a > acc_t'(SAMPLE_MAX))      return SAMPLE_MAX;
    else if (a < acc_t'(SAMPLE_MIN)) return SAMPLE_MIN;
    else                             return sample_t'(a);
  endfunction

  function automatic logic is_clipped(input acc_t a);
    return (a > acc_t'(SAMPLE_MAX)) || (a < acc_t'(SAMPLE_MIN));
  endfunction

`ifdef SOFT_MUTE_EN
  // Gain is in 1/64 units; the shift floors toward -inf, gain 64 is unity.
  function automatic sample_t apply_gain(input sample_t s, input logic [GAIN_W-1:0] g);
    logic signed [SAMPLE_W+GAIN_W:0] p;
    p = s * $signed({1'b0, g});
    return sample_t'(p >>> 6);
  endfunction
`endif

  state_e                state_q, state_d;
  logic [SLOT_W-1:0]     slot_q, slot_d;
  acc_t                  acc_q, acc_d;
  logic                  urun_acc_q, urun_acc_d;
  sample_t               held_q [NUM_VOICES];
  sample_t               held_d [NUM_VOICES];
  sample_t               vdata  [NUM_VOICES];
  sample_t               audio_q, audio_d;
  logic                  audio_valid_q, audio_valid_d;
  logic                  clip_q, clip_d;
  logic                  underrun_q, underrun_d;
  logic [NUM_VOICES-1:0] ready;
  logic                  tick;
  sample_t               sat;
`ifdef SOFT_MUTE_EN
  logic [GAIN_W-1:0]     gain_q, gain_d;
`endif

  sample_tick_gen #(
    .SAMPLE_DIV (SAMPLE_DIV)
  ) u_tick (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .tick_o (tick)
  );

  // State register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Next-state: tick starts a gather pass, one cycle per voice, then scale and output.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (tick) state_d = ST_GATHER;
      ST_GATHER: if (slot_q == LAST_SLOT) state_d = ST_SCALE;
      ST_SCALE:  state_d = ST_OUT;
      ST_OUT:    state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // FSM outputs: ready is one-hot on the active slot, independent of valid.
  always_comb begin
    ready = '0;
    if (state_q == ST_GATHER) ready = NUM_VOICES'(1) << slot_q;
  end

  // Unpack the flat voice data bus into per-voice samples.
  always_comb begin
    for (int k = 0; k < NUM_VOICES; k++) vdata[k] = sample_t'(bus.voice_data_i[SAMPLE_W*k +: SAMPLE_W]);
  end

  // Datapath: accumulate per slot, then saturate, mute and register the output sample.
  always_comb begin
    slot_d        = slot_q;
    acc_d         = acc_q;
    urun_acc_d    = urun_acc_q;
    held_d        = held_q;
    audio_d       = audio_q;
    audio_valid_d = 1'b0;
    clip_d        = 1'b0;
    underrun_d    = 1'b0;
    sat           = saturate(acc_q);
`ifdef SOFT_MUTE_EN
    gain_d        = gain_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (tick) begin
          slot_d     = '0;
          acc_d      = '0;
          urun_acc_d = 1'b0;
        end
      end
      ST_GATHER: begin
        if (bus.voice_valid_i[slot_q]) begin
          acc_d          = acc_q + acc_t'(vdata[slot_q]);
          held_d[slot_q] = vdata[slot_q];
        end else begin
          acc_d      = acc_q + acc_t'(held_q[slot_q]);
          urun_acc_d = 1'b1;
        end
        slot_d = slot_q + SLOT_W'(1);
      end
      ST_SCALE: begin
        clip_d        = is_clipped(acc_q);
        underrun_d    = urun_acc_q;
        audio_valid_d = 1'b1;
`ifdef SOFT_MUTE_EN
        if (bus.enable_i) gain_d = (gain_q == GAIN_W'(GAIN_MAX)) ? gain_q : gain_q + GAIN_W'(1);
        else              gain_d = (gain_q == '0) ? gain_q : gain_q - GAIN_W'(1);
        audio_d = apply_gain(sat, gain_d);
`else
        audio_d = bus.enable_i ? sat : '0;
`endif
      end
      default: ;
    endcase
  end

  // Datapath registers; reset discards any partial sum and pending strobe.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      slot_q        <= '0;
      acc_q         <= '0;
      urun_acc_q    <= 1'b0;
      for (int k = 0; k < NUM_VOICES; k++) held_q[k] <= '0;
      audio_q       <= '0;
      audio_valid_q <= 1'b0;
      clip_q        <= 1'b0;
      underrun_q    <= 1'b0;
`ifdef SOFT_MUTE_EN
      gain_q        <= '0;
`endif
    end else begin
      slot_q        <= slot_d;
      acc_q         <= acc_d;
      urun_acc_q    <= urun_acc_d;
      held_q        <= held_d;
      audio_q       <= audio_d;
      audio_valid_q <= audio_valid_d;
      clip_q        <= clip_d;
      underrun_q    <= underrun_d;
`ifdef SOFT_MUTE_EN
      gain_q        <= gain_d;
`endif
    end
  end

  assign bus.voice_ready_o = ready;
  assign bus.audio_valid_o = audio_valid_q;
  assign bus.audio_o       = audio_q;
  assign bus.clip_o        = clip_q;
  assign bus.underrun_o    = underrun_q;

endmodule

// File: tb/tb_audio_sample_scheduler.sv
// Directed testbench for audio_sample_scheduler (SAMPLE_DIV=16, NUM_VOICES=3).
// Default build exercises the hard-mute path; with SOFT_MUTE_EN defined the
// gain ramp scenario replaces the hard-mute scenarios.
module tb_audio_sample_scheduler;
  import audio_pkg::*;

  localparam int NV  = 3;
  localparam int DIV = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_pass   = 0;

  audio_sample_scheduler_if #(.NUM_VOICES(NV)) bus();

  audio_sample_scheduler #(
    .NUM_VOICES (NV),
    .SAMPLE_DIV (DIV)
  ) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic set_voices(input int a, input int b, input int c);
    sample_t sa, sb, sc;
    sa = sample_t'(a);
    sb = sample_t'(b);
    sc = sample_t'(c);
    bus.voice_data_i = {sc, sb, sa};
  endtask

  // Advance to the next output strobe; a missing strobe ends the run.
  task automatic next_strobe();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 4 * DIV; i++) begin
      @(posedge clk); #1;
      if (bus.audio_valid_o === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      $display("FAIL strobe_timeout: no audio_valid_o within %0d cycles", 4 * DIV);
      $fatal(1, "strobe timeout");
    end
  endtask

  // Release reset just after an edge (cycle 0) and check strobe/ready timing.
  task automatic check_timing(input string name, input int last_cycle);
    logic [NV-1:0] er;
    logic          ev;
    @(posedge clk); #1;
    rst = 1'b0;
    for (int c = 0; c <= last_cycle; c++) begin
      if (c > 0) begin
        @(posedge clk); #1;
      end
      er = '0;
      ev = 1'b0;
      if (c >= DIV && ((c - DIV) % DIV) < NV) er = NV'(1) << ((c - DIV) % DIV);
      if (c >= DIV + NV + 1 && ((c - (DIV + NV + 1)) % DIV) == 0) ev = 1'b1;
      n_checks++;
      if (bus.audio_valid_o !== ev || bus.voice_ready_o !== er)
        $display("FAIL %s cycle %0d: valid=%b ready=%b, expected valid=%b ready=%b",
                 name, c, bus.audio_valid_o, bus.voice_ready_o, ev, er);
      else n_pass++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if (bus.audio_valid_o !== 1'b0 || bus.voice_ready_o !== '0 || bus.audio_o !== sample_t'(0) ||
        bus.clip_o !== 1'b0 || bus.underrun_o !== 1'b0)
      $display("FAIL reset_outputs: valid=%b ready=%b audio=%0d clip=%b underrun=%b, expected all 0",
               bus.audio_valid_o, bus.voice_ready_o, bus.audio_o, bus.clip_o, bus.underrun_o);
    else n_pass++;
    check_timing("reset_timing", 3 * DIV + NV + 1);
  endtask

  task automatic test_sum();
    set_voices(1000, 2000, -500);
    bus.voice_valid_i = 3'b111;
    bus.enable_i = 1'b1;
    next_strobe();
    n_checks++;
    if (bus.audio_o !== sample_t'(2500) || bus.clip_o !== 1'b0 || bus.underrun_o !== 1'b0)
      $display("FAIL sum: audio=%0d clip=%b underrun=%b, expected 2500 0 0",
               bus.audio_o, bus.clip_o, bus.underrun_o);
    else n_pass++;
    @(posedge clk); #1;
    n_checks++;
    if (bus.audio_o !== sample_t'(2500) || bus.audio_valid_o !== 1'b0 ||
        bus.clip_o !== 1'b0 || bus.underrun_o !== 1'b0)
      $display("FAIL sum_hold: audio=%0d valid=%b, expected 2500 0", bus.audio_o, bus.audio_valid_o);
    else n_pass++;
  endtask

  task automatic test_clip();
    set_voices(8000, 8000, 8000);
    next_strobe();
    n_checks++;
    if (bus.audio_o !== sample_t'(8191) || bus.clip_o !== 1'b1 || bus.underrun_o !== 1'b0)
      $display("FAIL clip_pos: audio=%0d clip=%b, expected 8191 1", bus.audio_o, bus.clip_o);
    else n_pass++;
    set_voices(-8192, -8192, -8192);
    next_strobe();
    n_checks++;
    if (bus.audio_o !== sample_t'(-8192) || bus.clip_o !== 1'b1)
      $display("FAIL clip_neg: audio=%0d clip=%b, expected -8192 1", bus.audio_o, bus.clip_o);
    else n_pass++;
    set_voices(8191, 1, -1);
    next_strobe();
    n_checks++;
    if (bus.audio_o !== sample_t'(8191) || bus.clip_o !== 1'b0)
      $display("FAIL clip_edge: audio=%0d clip=%b, expected 8191 0", bus.audio_o, bus.clip_o);
    else n_pass++;
  endtask

  task automatic test_underrun();
    set_voices(1000, 2000, -500);
    bus.voice_valid_i = 3'b111;
    next_strobe();
    n_checks++;
    if (bus.audio_o !== sample_t'(2500) || bus.underrun_o !== 1'b0)
      $display("FAIL underrun_pre: audio=%0d underrun=%b, expected 2500 0", bus.audio_o, bus.underrun_o);
    else n_pass++;
    set_voices(1000, 7777, -500);
    bus.voice_valid_i = 3'b101;
    next_strobe();
    n_checks++;
    if (bus.audio_o !== sample_t'(2500) || bus.underrun_o !== 1'b1 || bus.clip_o !== 1'b0)
      $display("FAIL underrun_hit: audio=%0d underrun=%b clip=%b, expected 2500 1 0",
               bus.audio_o, bus.underrun_o, bus.clip_o);
    else n_pass++;
    @(posedge clk); #1;
    n_checks++;
    if (bus.underrun_o !== 1'b0)
      $display("FAIL underrun_pulse: underrun=%b one cycle after strobe, expected 0", bus.underrun_o);
    else n_pass++;
    set_voices(1000, 2000, -500);
    bus.voice_valid_i = 3'b111;
    next_strobe();
    n_checks++;
    if (bus.audio_o !== sample_t'(2500) || bus.underrun_o !== 1'b0)
      $display("FAIL underrun_post: audio=%0d underrun=%b, expected 2500 0", bus.audio_o, bus.underrun_o);
    else n_pass++;
  endtask

  task automatic test_enable();
    bus.enable_i = 1'b0;
    next_strobe();
    n_checks++;
    if (bus.audio_o !== sample_t'(0) || bus.clip_o !== 1'b0)
      $display("FAIL mute: audio=%0d clip=%b, expected 0 0", bus.audio_o, bus.clip_o);
    else n_pass++;
    bus.enable_i = 1'b1;
    next_strobe();
    n_checks++;
    if (bus.audio_o !== sample_t'(2500))
      $display("FAIL unmute: audio=%0d, expected 2500", bus.audio_o);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    bit found;
    set_voices(1000, 2000, -500);
    bus.voice_valid_i = 3'b111;
    bus.enable_i = 1'b1;
    next_strobe();
    found = 1'b0;
    for (int i = 0; i < 4 * DIV; i++) begin
      @(posedge clk); #1;
      if (bus.voice_ready_o === 3'b010) begin
        found = 1'b1;
        break;
      end
    end
    n_checks++;
    if (!found) $display("FAIL reset_mid_slot1: voice_ready_o never 010 within %0d cycles", 4 * DIV);
    else n_pass++;
    rst = 1'b1;
    #1;
    n_checks++;
    if (bus.voice_ready_o !== '0 || bus.audio_valid_o !== 1'b0 || bus.audio_o !== sample_t'(0))
      $display("FAIL reset_mid_async: ready=%b valid=%b audio=%0d, expected 000 0 0",
               bus.voice_ready_o, bus.audio_valid_o, bus.audio_o);
    else n_pass++;
    check_timing("reset_mid_timing", 2 * DIV + NV + 1);
    n_checks++;
    if (bus.audio_o !== sample_t'(2500))
      $display("FAIL reset_mid_sum: audio=%0d, expected 2500", bus.audio_o);
    else n_pass++;
  endtask

`ifdef SOFT_MUTE_EN
  task automatic test_soft_mute();
    rst = 1'b1;
    set_voices(6400, 0, 0);
    bus.voice_valid_i = 3'b111;
    bus.enable_i = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    for (int n = 1; n <= 64; n++) begin
      next_strobe();
      n_checks++;
      if (bus.audio_o !== sample_t'(100 * n))
        $display("FAIL ramp_up %0d: audio=%0d, expected %0d", n, bus.audio_o, 100 * n);
      else n_pass++;
    end
    bus.enable_i = 1'b0;
    for (int n = 1; n <= 64; n++) begin
      next_strobe();
      n_checks++;
      if (bus.audio_o !== sample_t'(6400 - 100 * n))
        $display("FAIL ramp_down %0d: audio=%0d, expected %0d", n, bus.audio_o, 6400 - 100 * n);
      else n_pass++;
    end
    bus.enable_i = 1'b1;
    for (int n = 1; n <= 64; n++) begin
      next_strobe();
      n_checks++;
      if (bus.audio_o !== sample_t'(100 * n))
        $display("FAIL ramp_again %0d: audio=%0d, expected %0d", n, bus.audio_o, 100 * n);
      else n_pass++;
    end
  endtask
`endif

  initial begin
    bus.enable_i      = 1'b1;
    bus.voice_valid_i = 3'b111;
    bus.voice_data_i  = '0;
    test_reset();
`ifdef SOFT_MUTE_EN
    test_soft_mute();
`else
    test_sum();
    test_clip();
    test_underrun();
    test_enable();
    test_reset_mid();
`endif
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/audio_sample_scheduler.md
# audio_sample_scheduler

Sample-rate scheduler sitting in front of the delta-sigma DAC. It generates the output sample tick and collects one sample per tick from each voice requester over a valid/ready handshake, visiting the voices in a fixed time-multiplexed order. It sums and saturates the samples, optionally applies a click-free mute ramp, and presents a 14-bit signed sample with a one-cycle valid strobe to the DAC's audio_valid_i/audio_i inputs.

## Interface
- NUM_VOICES, 3: number of voice requesters; legal range 1..8.
- SAMPLE_DIV, 1042: clock cycles per output sample (50 MHz / 1042 ≈ 48 kHz); must be ≥ NUM_VOICES+4.
- clk_i  in  1  system clock, 50 MHz.
- rst_i  in  1  reset, asynchronous, active-high.
- enable_i  in  1  audio enable; low mutes the output.
- voice_valid_i  in  NUM_VOICES  bit k: voice k sample available.
- voice_data_i  in  14*NUM_VOICES  signed samples, voice k in bits [14k+13:14k].
- voice_ready_o  out  NUM_VOICES  bit k: scheduler accepts voice k this cycle.
- audio_valid_o  out  1  one-cycle strobe, new output sample.
- audio_o  out  14  signed output sample; holds its value between strobes.
- clip_o  out  1  high with audio_valid_o if saturation occurred.
- underrun_o  out  1  high with audio_valid_o if any voice was missing.

## Operation
- Tick counter runs 0..SAMPLE_DIV-1 and wraps. The tick fires when the count equals SAMPLE_DIV-1. The counter runs regardless of FSM state.
- FSM states: IDLE, GATHER, SCALE, OUT.
  - IDLE -> GATHER on tick, with slot index = 0 and accumulator = 0.
  - GATHER lasts NUM_VOICES cycles, one per voice in ascending index order.
  - GATHER (last slot) -> SCALE -> OUT -> IDLE.
- GATHER, slot k:
  - voice_ready_o[k] = 1; every other bit is 0. Ready does not depend on valid.
  - Transfer occurs when valid & ready: add voice_data_i[k] and store it in held[k].
  - If voice_valid_i[k]=0: add held[k] (last accepted value; 0 after reset) and set the underrun flag.
- Accumulator is 17-bit signed with sign-extended adds. No wrap is possible for N ≤ 8.
- SCALE:
  - Saturate the accumulator to [-8192, 8191]. Set the clip flag if a limit was applied.
  - Apply the mute stage; enable_i is sampled in this cycle only.
- OUT: register audio_o, assert audio_valid_o, clip_o and underrun_o for exactly this cycle, then clear both flags.
- A tick occurring outside IDLE cannot happen by construction, because SAMPLE_DIV ≥ NUM_VOICES+4.

## Timing
- Reset values: audio_o=0, audio_valid_o=0, voice_ready_o=0, clip_o=0, underrun_o=0, counter=0, state=IDLE, held[*]=0, gain=0.
- Tick in cycle T: slot k is active in cycle T+1+k; SCALE in T+NUM_VOICES+1; audio_valid_o in T+NUM_VOICES+2.
- The first tick after reset release is in cycle SAMPLE_DIV-1. After that, one strobe every SAMPLE_DIV cycles exactly.
- Reset mid-operation: every register returns to its reset value immediately, a partial sum is discarded, and no strobe is emitted.

## Configuration
- SOFT_MUTE_EN defined:
  - 7-bit gain register, range 0..64, reset value 0.
  - In each SCALE cycle, gain steps +1 toward 64 if enable_i=1, otherwise -1 toward 0.
  - Output = (sat × gain) >>> 6, an arithmetic shift (rounds toward -inf). Gain 64 passes the sample through unchanged.
- SOFT_MUTE_EN undefined: output = enable_i ? sat : 0. No gain register exists.

## Structure
- Shared package audio_pkg: SAMPLE_W=14, typedef sample_t (logic signed [13:0]), SAMPLE_MAX/SAMPLE_MIN constants, FSM state enum.
- One sub-module: sample_tick_gen (the SAMPLE_DIV counter and tick pulse), reusable by other rate-driven blocks.

## Test plan
All tests use SAMPLE_DIV=16, NUM_VOICES=3, and SOFT_MUTE_EN undefined unless stated.
1. Reset release -> all outputs 0; first audio_valid_o in cycle 20, then in cycles 36, 52, …; voice_ready_o one-hot in cycles 16, 17, 18.
2. Voices 1000, 2000, -500 always valid, enable_i=1 -> audio_o=2500, clip_o=0, underrun_o=0.
3. Voices 8000×3 -> audio_o=8191 and clip_o=1; voices -8192×3 -> audio_o=-8192 and clip_o=1.
4. After test 2, drop voice_valid_i[1] for one tick -> audio_o=2500 (held 2000 used), underrun_o=1 for that strobe only.
5. SOFT_MUTE_EN defined, constant sum 6400, gain at 64:
   - Drop enable_i -> successive outputs 6300, 6200, …, reaching 0 after 64 strobes.
   - Re-enable -> output ramps back up to 6400.
6. Assert rst_i during slot 1 -> voice_ready_o=0 immediately, no strobe; next strobe 20 cycles after rst_i deasserts.
